// File: rtl/spi_slave_sys_if.sv
// Bundles the SPI pins and the system-side byte handshake of spi_slave_sys.
// The master modport is the side that drives SCK/select/MOSI and consumes received bytes.
interface spi_slave_sys_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  spiClk_i;
   logic                  ss_n;
   logic                  mosi;
   logic                  miso;
   logic [DATA_WIDTH-1:0] tx_byte;
   logic                  tx_load;
   logic                  tx_ready;
   logic [DATA_WIDTH-1:0] rx_byte;
   logic                  rx_valid;
   logic                  rx_ack;
   logic                  overrun;
   logic                  busy;

   modport master (
      output spiClk_i, ss_n, mosi, tx_byte, tx_load, rx_ack,
      input  miso, tx_ready, rx_byte, rx_valid, overrun, busy
   );

   modport slave (
      input  spiClk_i, ss_n, mosi, tx_byte, tx_load, rx_ack,
      output miso, tx_ready, rx_byte, rx_valid, overrun, busy
   );
endinterface

// File: rtl/spi_slave_sys.sv
// Mode-0 SPI slave clocked only by sysClk: SPI pins are oversampled through
// synchronizers and the shifter advances on detected SCK edges.
module spi_slave_sys #(
   parameter int unsigned           DATA_WIDTH  = 8,
   parameter int unsigned           SYNC_STAGES = 2,
   parameter logic [DATA_WIDTH-1:0] IDLE_FILL   = 8'hFF
) (
   input logic            sysClk,
   input logic            reset,
   spi_slave_sys_if.slave bus
);

   localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

   logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
   logic                   sck_d_q, ss_d_q;

   state_e                 state_q;
   logic [CntW-1:0]        bitcnt_q;
   logic [DATA_WIDTH-1:0]  tx_sh_q, rx_sh_q, hold_q, rx_byte_q;
   logic                   tx_ready_q, rx_valid_q, overrun_q, busy_q, miso_q, reload_q;

   logic                   sck_s, ss_s, mosi_s;
   logic                   sck_rise, sck_fall, ss_fall, ss_rise;
   logic                   abort, load_now, reload_now, tx_consume, tx_accept, word_done;
   logic [DATA_WIDTH-1:0]  tx_next, rx_word;

   always_ff @(posedge sysClk) begin
      if (!reset) begin
         sck_sync_q  <= '0;
         ss_sync_q   <= '1;
         mosi_sync_q <= '0;
         sck_d_q     <= 1'b0;
         ss_d_q      <= 1'b1;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.spiClk_i};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.ss_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
         sck_d_q     <= sck_sync_q[SYNC_STAGES-1];
         ss_d_q      <= ss_sync_q[SYNC_STAGES-1];
      end
   end

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign ss_s     = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_d_q;
   assign sck_fall = ~sck_s & sck_d_q;
   assign ss_fall  = ~ss_s & ss_d_q;
   assign ss_rise  = ss_s & ~ss_d_q;

   assign abort      = ss_rise && (state_q != StIdle);
   assign load_now   = (state_q == StLoad) && !ss_rise;
   assign reload_now = (state_q == StShift) && !ss_rise && sck_fall && reload_q;
   // A word taken from the holding register frees it in the same cycle, so a
   // simultaneous tx_load lands behind the consumed value.
   assign tx_consume = (load_now || reload_now) && !tx_ready_q;
   assign tx_accept  = bus.tx_load && (tx_ready_q || tx_consume);
   assign tx_next    = tx_ready_q ? IDLE_FILL : hold_q;
   assign rx_word    = {rx_sh_q[DATA_WIDTH-2:0], mosi_s};
   assign word_done  = (state_q == StShift) && !ss_rise && sck_rise && (bitcnt_q == LastBit);

   always_ff @(posedge sysClk) begin
      if (!reset) begin
         state_q    <= StIdle;
         bitcnt_q   <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         hold_q     <= '0;
         rx_byte_q  <= '0;
         tx_ready_q <= 1'b1;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
         busy_q     <= 1'b0;
         miso_q     <= 1'b0;
         reload_q   <= 1'b0;
      end else begin
         if (tx_accept) begin
            hold_q     <= bus.tx_byte;
            tx_ready_q <= 1'b0;
         end else if (tx_consume) begin
            tx_ready_q <= 1'b1;
         end

         // A completing word outranks an ack arriving in the same cycle.
         if (word_done) begin
            rx_byte_q  <= rx_word;
            rx_valid_q <= 1'b1;
            if (rx_valid_q && !bus.rx_ack) overrun_q <= 1'b1;
         end else if (bus.rx_ack) begin
            rx_valid_q <= 1'b0;
         end

         if (abort) begin
            state_q  <= StIdle;
            miso_q   <= 1'b0;
            busy_q   <= 1'b0;
            bitcnt_q <= '0;
            reload_q <= 1'b0;
            rx_sh_q  <= '0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  miso_q <= 1'b0;
                  busy_q <= 1'b0;
                  if (ss_fall) state_q <= StLoad;
               end
               StLoad: begin
                  tx_sh_q   <= tx_next;
                  miso_q    <= tx_next[DATA_WIDTH-1];
                  bitcnt_q  <= '0;
                  busy_q    <= 1'b1;
                  overrun_q <= 1'b0;
                  reload_q  <= 1'b0;
                  state_q   <= StShift;
               end
               StShift: begin
                  if (sck_rise) begin
                     rx_sh_q <= rx_word;
                     if (bitcnt_q == LastBit) begin
                        bitcnt_q <= '0;
                        reload_q <= 1'b1;
                     end else begin
                        bitcnt_q <= bitcnt_q + CntW'(1);
                     end
                  end else if (sck_fall) begin
                     if (reload_q) begin
                        tx_sh_q  <= tx_next;
                        miso_q   <= tx_next[DATA_WIDTH-1];
                        reload_q <= 1'b0;
                     end else begin
                        tx_sh_q <= {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
                        miso_q  <= tx_sh_q[DATA_WIDTH-2];
                     end
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign bus.miso     = miso_q;
   assign bus.tx_ready = tx_ready_q;
   assign bus.rx_byte  = rx_byte_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.overrun  = overrun_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_spi_slave_sys.sv
// Bench for spi_slave_sys: a cycle-timed mode-0 master with scoreboards for the
// bytes the slave should receive and the bytes the master should read back.
module tb_spi_slave_sys;
   localparam int unsigned Half = 8;

   logic sysClk = 1'b0;
   logic reset  = 1'b0;

   spi_slave_sys_if #(.DATA_WIDTH(8)) bus ();

   spi_slave_sys #(
      .DATA_WIDTH (8),
      .SYNC_STAGES(2),
      .IDLE_FILL  (8'hFF)
   ) dut (
      .sysClk(sysClk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 sysClk = ~sysClk;

   int checks   = 0;
   int failures = 0;
   logic [7:0] rx_q[$];
   logic [7:0] miso_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge sysClk);
      #1;
   endtask

   task automatic load_tx(input logic [7:0] v);
      bus.tx_byte = v;
      bus.tx_load = 1'b1;
      miso_q.push_back(v);
      cycles(1);
      bus.tx_load = 1'b0;
   endtask

   task automatic ack_rx();
      bus.rx_ack = 1'b1;
      cycles(1);
      bus.rx_ack = 1'b0;
      cycles(1);
      check("rx_valid_cleared", bus.rx_valid, 1'b0);
   endtask

   task automatic begin_xfer();
      bus.ss_n = 1'b0;
      cycles(6);
      check("busy_in_xfer", bus.busy, 1'b1);
      check("tx_ready_after_load", bus.tx_ready, 1'b1);
   endtask

   task automatic end_xfer();
      cycles(Half);
      bus.ss_n = 1'b1;
      cycles(5);
      check("busy_after_end", bus.busy, 1'b0);
      check("miso_after_end", bus.miso, 1'b0);
   endtask

   // Shifts nbits of mo MSB first; a full word is scored on both directions.
   task automatic spi_word(input logic [7:0] mo, input int nbits, input bit do_ack,
                           input bit ack_at_done);
      logic [7:0] mi = '0;
      logic [7:0] exp;
      if (nbits == 8) rx_q.push_back(mo);
      for (int i = 7; i >= 8 - nbits; i--) begin
         bus.mosi = mo[i];
         cycles(Half);
         mi[i] = bus.miso;
         bus.spiClk_i = 1'b1;
         if (i == 0 && ack_at_done) begin
            // Lands rx_ack on the cycle the synced rising edge completes the word.
            cycles(2);
            bus.rx_ack = 1'b1;
            cycles(1);
            bus.rx_ack = 1'b0;
            cycles(Half - 3);
         end else begin
            cycles(Half);
         end
         bus.spiClk_i = 1'b0;
      end
      if (nbits == 8) begin
         cycles(4);
         check("miso_sb_nonempty", miso_q.size() != 0, 1'b1);
         if (miso_q.size() != 0) begin
            exp = miso_q.pop_front();
            check("master_rx_byte", mi, exp);
         end
         check("rx_valid_set", bus.rx_valid, 1'b1);
         check("rx_sb_nonempty", rx_q.size() != 0, 1'b1);
         if (rx_q.size() != 0) begin
            exp = rx_q.pop_front();
            check("rx_byte", bus.rx_byte, exp);
         end
         if (do_ack) ack_rx();
      end
   endtask

   initial begin
      bus.spiClk_i = 1'b0;
      bus.ss_n     = 1'b0;
      bus.mosi     = 1'b1;
      bus.tx_byte  = '0;
      bus.tx_load  = 1'b0;
      bus.rx_ack   = 1'b0;

      // Reset held while the SPI lines are active.
      for (int i = 0; i < 3; i++) begin
         @(posedge sysClk);
         #1;
         bus.spiClk_i = ~bus.spiClk_i;
      end
      check("rst_miso", bus.miso, 1'b0);
      check("rst_tx_ready", bus.tx_ready, 1'b1);
      check("rst_rx_byte", bus.rx_byte, 8'h00);
      check("rst_rx_valid", bus.rx_valid, 1'b0);
      check("rst_overrun", bus.overrun, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      bus.spiClk_i = 1'b0;
      bus.ss_n     = 1'b1;
      bus.mosi     = 1'b0;
      cycles(1);
      reset = 1'b1;
      cycles(4);
      check("post_rst_rx_valid", bus.rx_valid, 1'b0);
      check("post_rst_busy", bus.busy, 1'b0);

      // Single word.
      load_tx(8'hA5);
      check("tx_ready_after_tx_load", bus.tx_ready, 1'b0);
      begin_xfer();
      spi_word(8'h3C, 8, 1'b1, 1'b0);
      end_xfer();

      // Two words under one select.
      load_tx(8'h12);
      begin_xfer();
      load_tx(8'h34);
      check("tx_ready_second_load", bus.tx_ready, 1'b0);
      spi_word(8'h81, 8, 1'b1, 1'b0);
      spi_word(8'h7E, 8, 1'b1, 1'b0);
      check("two_word_overrun", bus.overrun, 1'b0);
      check("two_word_tx_ready", bus.tx_ready, 1'b1);
      end_xfer();

      // Underrun: nothing loaded, fill pattern goes out.
      miso_q.push_back(8'hFF);
      begin_xfer();
      spi_word(8'h55, 8, 1'b1, 1'b0);
      end_xfer();

      // Overrun: two unacknowledged words.
      miso_q.push_back(8'hFF);
      miso_q.push_back(8'hFF);
      begin_xfer();
      spi_word(8'h01, 8, 1'b0, 1'b0);
      check("no_overrun_first", bus.overrun, 1'b0);
      spi_word(8'h02, 8, 1'b0, 1'b0);
      check("overrun_set", bus.overrun, 1'b1);
      end_xfer();
      check("overrun_sticky", bus.overrun, 1'b1);
      ack_rx();

      // New transaction clears overrun; ack coinciding with completion avoids it.
      miso_q.push_back(8'hFF);
      miso_q.push_back(8'hFF);
      begin_xfer();
      check("overrun_cleared_at_load", bus.overrun, 1'b0);
      spi_word(8'hAA, 8, 1'b0, 1'b0);
      spi_word(8'hBB, 8, 1'b1, 1'b1);
      check("ack_at_done_overrun", bus.overrun, 1'b0);
      end_xfer();

      // Abort after five bits.
      begin_xfer();
      spi_word(8'hB0, 5, 1'b0, 1'b0);
      end_xfer();
      check("abort_rx_valid", bus.rx_valid, 1'b0);
      check("abort_rx_byte_kept", bus.rx_byte, 8'hBB);
      miso_q.push_back(8'hFF);
      begin_xfer();
      spi_word(8'hC3, 8, 1'b1, 1'b0);
      end_xfer();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/spi_slave_sys.md
Name: spi_slave_sys

Overview:
- Mode-0 SPI slave running entirely in the sysClk domain.
- Consumes the gated outSpiClk, mosi and active-low select (the master's tx_en) produced by the SPI master.
- Returns miso to the master and presents received bytes to the system side.
- Oversamples the SPI lines through synchronizers and acts on detected SCK edges; no logic is clocked by the SPI clock.

Parameters:
DATA_WIDTH, 8, bits per SPI word (bit counter sized $clog2(DATA_WIDTH))
SYNC_STAGES, 2, flip-flop depth of each input synchronizer (min 2)
IDLE_FILL, 8'hFF, word shifted out when no tx word is loaded (underrun)

Ports:
sysClk  input  1  system clock; all state sampled on posedge
reset  input  1  synchronous, active-low reset
spiClk_i  input  1  async SPI clock from master (idles low)
ss_n  input  1  async slave select, active low
mosi  input  1  async serial data from master
miso  output  1  serial data to master
tx_byte  input  DATA_WIDTH  word to transmit next
tx_load  input  1  write tx_byte into holding register (honoured only when tx_ready=1)
tx_ready  output  1  holding register empty
rx_byte  output  DATA_WIDTH  last complete received word
rx_valid  output  1  rx_byte holds an unacknowledged word
rx_ack  input  1  consume rx_byte
overrun  output  1  sticky: a word completed while rx_valid=1
busy  output  1  transaction in progress (synced ss_n low)

Behaviour:
- Reset (reset=0 at posedge): miso=0, tx_ready=1, rx_byte=0, rx_valid=0, overrun=0, busy=0; bit counter=0; shift registers=0; synchronizer flops=0 except ss_n chain=1; state=IDLE. Reset wins over every other input, including mid-transaction.
- Sync: spiClk_i, ss_n, mosi each pass through SYNC_STAGES flops.
- Edge detect: one extra register per synchronized line. SCK rise/fall are single-cycle pulses, SYNC_STAGES+1 cycles after the pin edge.
- Clock ratio: sysClk ≥ 8× spiClk, required so miso settles within a half SCK period.
- States:
  - IDLE: miso=0, busy=0. Synced ss_n falling edge -> LOAD.
  - LOAD (1 cycle): tx shift reg <= holding reg if tx_ready=0 (then tx_ready<=1), else IDLE_FILL. miso <= MSB. bitcnt<=0, busy=1. -> SHIFT.
  - SHIFT, on SCK rise: rx shift <= {rx shift[DATA_WIDTH-2:0], mosi_sync}; bitcnt++.
  - SHIFT, on the rise where bitcnt==DATA_WIDTH-1: rx_byte <= assembled word; rx_valid<=1; overrun<=1 if rx_valid already 1 and no rx_ack this cycle; bitcnt<=0; set reload flag.
  - SHIFT, on SCK fall: if reload flag, reload tx shift exactly as in LOAD and clear the flag; else shift left. miso <= new MSB.
  - Any state except IDLE: synced ss_n rise -> IDLE next cycle. Partial word discarded, no rx_valid, bitcnt=0, miso=0. Holding register and rx_byte untouched.
- Handshakes:
  - tx_load with tx_ready=1: holding <= tx_byte, tx_ready<=0 next cycle. tx_load with tx_ready=0 is ignored.
  - Reload and tx_load in the same cycle: reload consumes the old value first, then the new value is written; tx_ready stays 0.
  - rx_ack clears rx_valid next cycle. rx_ack in the same cycle as a word completion: new word wins, rx_valid stays 1, no overrun.
- overrun clears only on reset or at the LOAD of a new transaction.
- Multi-byte: words back-to-back while ss_n is held low; no return to LOAD between words.
- Word order: MSB first in both directions.

Test Plan:
- Reset: hold reset=0 for 3 cycles during SCK toggling -> all outputs at reset values, no rx_valid.
- Single word: load 0xA5, master sends 0x3C -> rx_byte=0x3C with rx_valid=1; master receives 0xA5; tx_ready returns to 1 at LOAD.
- Two words, one select: load 0x12; load 0x34 after tx_ready rises; master sends 0x81, 0x7E -> rx 0x81 then 0x7E; master receives 0x12, 0x34; no overrun when each word is acked.
- Underrun: no tx_load, master sends 0x55 -> master receives 0xFF; rx_byte=0x55.
- Overrun: two words 0x01, 0x02 with no rx_ack -> rx_byte=0x02, overrun=1. A new transaction clears overrun. rx_ack coinciding with completion leaves overrun=0.
- Abort: ss_n deasserted after 5 bits -> no rx_valid, miso=0, busy=0. The next full transaction of 0xC3 is received correctly.
